// File: rtl/iram_pkg.sv
// ----------------------------------------------------------------------------
// iram_pkg: shared types/defaults for the 8051 internal RAM controller | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package iram_pkg;

    localparam int unsigned SP_RESET_DEFAULT = 32'h07;
    localparam int unsigned SP_LIMIT_DEFAULT = 32'hFF;

    typedef logic [15:0] stack_word_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUSH_LO   = 3'd1,
        PUSH_HI   = 3'd2,
        POP_RD_HI = 3'd3,
        POP_RD_LO = 3'd4,
        DONE      = 3'd5
    } stack_state_t;

endpackage

`default_nettype wire

// File: rtl/iram_array.sv
// ----------------------------------------------------------------------------
// iram_array: 2**ADDR_W x DATA_W RAM, sync write + sync read (read-old) | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iram_array
    import iram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are never reset; q keeps its last value while re is low.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/iram_stack_ctrl.sv
// ----------------------------------------------------------------------------
// iram_stack_ctrl: 8051 data RAM + multi-cycle stack engine; optional
// STACK_GUARD_EN rejects overflowing/underflowing stack ops | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iram_stack_ctrl
    import iram_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                port_ready,
    input  logic                push_req,
    input  logic                pop_req,
    input  logic                two_byte,
    input  logic [2*DATA_W-1:0] push_data,
    output logic [2*DATA_W-1:0] pop_data,
    output logic                stack_busy,
    output logic                stack_done,
    input  logic                sp_wr_en,
    input  logic [ADDR_W-1:0]   sp_wr_data,
    output logic [ADDR_W-1:0]   sp_out,
    output logic                stack_empty,
    output logic                stack_ovf,
    output logic                stack_unf
);

    stack_state_t        state, state_nxt;
    logic [ADDR_W-1:0]   sp;
    logic                is_pop;
    logic                is_two;
    logic                rejected;
    logic [2*DATA_W-1:0] push_buf;
    logic [DATA_W-1:0]   pop_hi;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_hold;

    logic                arr_we;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]   arr_wdata;
    logic                arr_re;
    logic [ADDR_W-1:0]   arr_raddr;
    logic [DATA_W-1:0]   arr_q;

    logic                accept;
    logic                req_reject;

    assign accept = (state == IDLE) && !sp_wr_en && (push_req || pop_req);

`ifdef STACK_GUARD_EN
    logic [ADDR_W:0] need;
    logic            push_reject;
    logic            pop_reject;
    logic            ovf;
    logic            unf;

    // Bounds are evaluated one bit wider so SP+k / SP-k cannot wrap.
    assign need        = two_byte ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    assign push_reject = ({1'b0, sp} + need) > {1'b0, SP_LIMIT};
    assign pop_reject  = {1'b0, sp} < ({1'b0, SP_RESET} + need);
    assign req_reject  = push_req ? push_reject : pop_reject;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (accept) begin
            if (push_req && push_reject) begin
                ovf <= 1'b1;
            end
            if (!push_req && pop_reject) begin
                unf <= 1'b1;
            end
        end
    end

    assign stack_ovf = ovf;
    assign stack_unf = unf;
`else
    assign req_reject = 1'b0;
    assign stack_ovf  = 1'b0;
    assign stack_unf  = 1'b0;
`endif

    iram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (arr_raddr),
        .q     (arr_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The data port owns the array in IDLE; the stack engine owns it otherwise.
    always_comb begin
        state_nxt = state;
        arr_we    = 1'b0;
        arr_waddr = wr_addr;
        arr_wdata = wr_data;
        arr_re    = 1'b0;
        arr_raddr = rd_addr;
        case (state)
            IDLE: begin
                arr_we = wr_en;
                arr_re = rd_en;
                if (accept) begin
                    if (push_req) begin
                        state_nxt = PUSH_LO;
                    end else if (two_byte && !req_reject) begin
                        state_nxt = POP_RD_HI;
                    end else begin
                        state_nxt = POP_RD_LO;
                    end
                end
            end
            PUSH_LO: begin
                arr_we    = !rejected;
                arr_waddr = sp + ADDR_W'(1);
                arr_wdata = push_buf[DATA_W-1:0];
                state_nxt = (is_two && !rejected) ? PUSH_HI : DONE;
            end
            PUSH_HI: begin
                arr_we    = 1'b1;
                arr_waddr = sp + ADDR_W'(1);
                arr_wdata = push_buf[2*DATA_W-1:DATA_W];
                state_nxt = DONE;
            end
            POP_RD_HI: begin
                arr_re    = 1'b1;
                arr_raddr = sp;
                state_nxt = POP_RD_LO;
            end
            POP_RD_LO: begin
                arr_re    = !rejected;
                arr_raddr = sp;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp       <= SP_RESET;
            is_pop   <= 1'b0;
            is_two   <= 1'b0;
            rejected <= 1'b0;
            push_buf <= '0;
            pop_hi   <= '0;
            rd_valid <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_valid <= (state == IDLE) && rd_en;
            rd_hold  <= rd_data;
            case (state)
                IDLE: begin
                    if (sp_wr_en) begin
                        sp <= sp_wr_data;
                    end else if (accept) begin
                        is_pop   <= !push_req;
                        is_two   <= two_byte;
                        rejected <= req_reject;
                        push_buf <= push_data;
                        pop_hi   <= '0;
                    end
                end
                PUSH_LO, PUSH_HI: begin
                    if (!rejected) begin
                        sp <= sp + ADDR_W'(1);
                    end
                end
                POP_RD_HI: begin
                    sp <= sp - ADDR_W'(1);
                end
                POP_RD_LO: begin
                    if (!rejected) begin
                        sp <= sp - ADDR_W'(1);
                        if (is_two) begin
                            pop_hi <= arr_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // rd_data tracks the array only for the cycle after an accepted read.
    assign rd_data     = rd_valid ? arr_q : rd_hold;
    assign pop_data    = (state == DONE && is_pop && !rejected) ? {pop_hi, arr_q} : '0;
    assign stack_busy  = (state != IDLE);
    assign stack_done  = (state == DONE);
    assign port_ready  = !stack_busy;
    assign sp_out      = sp;
    assign stack_empty = (sp == SP_RESET);

endmodule

`default_nettype wire

// File: tb/tb_iram_stack_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iram_stack_ctrl: directed scoreboard bench for iram_stack_ctrl | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_iram_stack_ctrl;
    import iram_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr, wr_data;
    logic [7:0]  rd_data;
    logic        port_ready;
    logic        push_req, pop_req, two_byte;
    logic [15:0] push_data, pop_data;
    logic        stack_busy, stack_done;
    logic        sp_wr_en;
    logic [7:0]  sp_wr_data, sp_out;
    logic        stack_empty, stack_ovf, stack_unf;

    iram_stack_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .port_ready  (port_ready),
        .push_req    (push_req),
        .pop_req     (pop_req),
        .two_byte    (two_byte),
        .push_data   (push_data),
        .pop_data    (pop_data),
        .stack_busy  (stack_busy),
        .stack_done  (stack_done),
        .sp_wr_en    (sp_wr_en),
        .sp_wr_data  (sp_wr_data),
        .sp_out      (sp_out),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clock = ~clock;

    typedef struct {
        stack_word_t pop;
        logic [7:0]  sp;
        int          cyc;
    } done_exp_t;

    done_exp_t  done_q[$];
    logic [7:0] rd_q[$];
    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    logic       rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        rd_pend = rd_en && port_ready && reset;
    end

    // Monitor: every presented read result / stack completion consumes one expectation.
    always @(negedge clock) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_q.size()), 32'd1);
            end else begin
                check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
        end
        if (stack_done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(done_q.size()), 32'd1);
            end else begin
                done_exp_t e;
                e = done_q.pop_front();
                check("pop_data", 32'(pop_data), 32'(e.pop));
                check("done_sp", 32'(sp_out), 32'(e.sp));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        rd_en = 1'b1; rd_addr = a;
        rd_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic set_sp(input logic [7:0] v);
        sp_wr_en = 1'b1; sp_wr_data = v;
        tick();
        sp_wr_en = 1'b0;
    endtask

    // lat = 0 issues the request without expecting a completion.
    task automatic issue_op(input logic p, input logic q, input logic two, input logic [15:0] d,
                            input logic [15:0] ep, input logic [7:0] es, input int lat);
        done_exp_t e;
        push_req = p; pop_req = q; two_byte = two; push_data = d;
        if (lat != 0) begin
            e.pop = ep; e.sp = es; e.cyc = cyc + lat;
            done_q.push_back(e);
        end
        tick();
        push_req = 1'b0; pop_req = 1'b0; two_byte = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (stack_busy && n < 8) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(stack_busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        push_req = 1'b0; pop_req = 1'b0; two_byte = 1'b0; push_data = '0;
        sp_wr_en = 1'b0; sp_wr_data = '0;
        tick(); tick();
        reset = 1'b1;
        check("rst_sp", 32'(sp_out), 32'h07);
        check("rst_empty", 32'(stack_empty), 32'd1);
        check("rst_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy_done", {30'd0, stack_busy, stack_done}, 32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_ready", 32'(port_ready), 32'd1);

        wr(8'h30, 8'h5A);
        rd(8'h30, 8'h5A);

        // Read and write of the same address in one cycle returns the old byte.
        wr(8'h31, 8'h11);
        rd_en = 1'b1; rd_addr = 8'h31; wr_en = 1'b1; wr_addr = 8'h31; wr_data = 8'h22;
        rd_q.push_back(8'h11);
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        rd(8'h31, 8'h22);

        issue_op(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 8'h09, 3);
        for (int i = 0; i < 3; i++) begin
            check("busy_ready", 32'(port_ready), 32'd0);
            tick();
        end
        check("ready_after", 32'(port_ready), 32'd1);
        rd(8'h08, 8'h34);
        rd(8'h09, 8'h12);

        issue_op(1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 8'h07, 3);
        wait_idle();
        check("pop2_empty", 32'(stack_empty), 32'd1);

        issue_op(1'b1, 1'b1, 1'b0, 16'h00AA, 16'h0000, 8'h08, 2);
        wait_idle();
        rd(8'h08, 8'hAA);

        issue_op(1'b0, 1'b1, 1'b0, 16'h0000, 16'h00AA, 8'h07, 2);
        wait_idle();
        tick();
        check("rd_hold", 32'(rd_data), 32'hAA);

        // Requests and SP loads while busy are ignored.
        issue_op(1'b1, 1'b0, 1'b0, 16'h0055, 16'h0000, 8'h08, 2);
        pop_req = 1'b1; two_byte = 1'b1; sp_wr_en = 1'b1; sp_wr_data = 8'h40;
        tick();
        pop_req = 1'b0; two_byte = 1'b0; sp_wr_en = 1'b0;
        wait_idle();
        check("busy_ignore_sp", 32'(sp_out), 32'h08);

        // SP load beats a simultaneous push.
        sp_wr_en = 1'b1; sp_wr_data = 8'h07; push_req = 1'b1; push_data = 16'h0099;
        tick();
        sp_wr_en = 1'b0; push_req = 1'b0;
        tick(); tick(); tick();
        check("sp_wr_priority", 32'(sp_out), 32'h07);
        rd(8'h08, 8'h55);

        wr(8'hFF, 8'h77);
        wr(8'h00, 8'h66);
        set_sp(8'hFE);
`ifdef STACK_GUARD_EN
        issue_op(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 8'hFE, 2);
        wait_idle();
        check("ovf_flag", {30'd0, stack_ovf, stack_unf}, 32'd2);
        rd(8'hFF, 8'h77);
        rd(8'h00, 8'h66);
`else
        issue_op(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 8'h00, 3);
        wait_idle();
        check("no_guard_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
        rd(8'hFF, 8'hEF);
        rd(8'h00, 8'hBE);
`endif

        wr(8'h07, 8'h3C);
        set_sp(8'h07);
`ifdef STACK_GUARD_EN
        issue_op(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h07, 2);
        wait_idle();
        check("unf_flag", {30'd0, stack_ovf, stack_unf}, 32'd3);
`else
        issue_op(1'b0, 1'b1, 1'b0, 16'h0000, 16'h003C, 8'h06, 2);
        wait_idle();
        check("wrap_sp", 32'(sp_out), 32'h06);
`endif

        // Reset in the third cycle of a two-byte pop aborts it.
        set_sp(8'h07);
        issue_op(1'b1, 1'b0, 1'b1, 16'hA5C3, 16'h0000, 8'h09, 3);
        wait_idle();
        issue_op(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 8'h00, 0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_sp", 32'(sp_out), 32'h07);
        check("abort_busy_done", {30'd0, stack_busy, stack_done}, 32'd0);
        check("abort_pop_data", 32'(pop_data), 32'd0);
        check("abort_flags", {30'd0, stack_ovf, stack_unf}, 32'd0);
        reset = 1'b1;
        tick();
        rd(8'h08, 8'hC3);
        rd(8'h09, 8'hA5);

        tick(); tick();
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
